// File: rtl/ped_crossing.sv
// ped_crossing -- pelican-style pedestrian crossing controller.
//
// A road green phase is held until a pedestrian request has been registered
// and the minimum green time has elapsed. The controller then walks the road
// through yellow and all-red, gives the pedestrians a walk phase and a
// clearance phase, and clears again through all-red before returning to green.
//
// Ports:
//   pin3_clk_16mhz   in   sole clock, rising edge
//   pin9_rst_n       in   asynchronous active-low reset
//   pin10_ped_button in   pedestrian push button, asynchronous, active-high
//   pin4_green       out  road green lamp
//   pin5_yellow      out  road yellow lamp
//   pin6_red         out  road red lamp
//   pin7_ped_green   out  pedestrian green (walk) lamp
//   pin8_ped_red     out  pedestrian red (don't walk) lamp
//   pin11_wait       out  request-registered indicator
//
// Configuration macro:
//   PED_FLASH_EN  when defined, the pedestrian green lamp flashes at 1 Hz
//                 during the clearance phase (pedestrian red dark); when
//                 undefined, the pedestrian red lamp is lit for the whole
//                 clearance phase.

module ped_crossing #(
    parameter int TIMER_SCALE = 16000000,
    parameter int T_MIN_GREEN = 10,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 2,
    parameter int T_WALK      = 8,
    parameter int T_CLEAR     = 4
) (
    input  logic pin3_clk_16mhz,
    input  logic pin9_rst_n,
    input  logic pin10_ped_button,
    output logic pin4_green,
    output logic pin5_yellow,
    output logic pin6_red,
    output logic pin7_ped_green,
    output logic pin8_ped_red,
    output logic pin11_wait
);

    localparam int PW = $clog2(TIMER_SCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(TIMER_SCALE - 1);
`ifdef PED_FLASH_EN
    localparam logic [PW-1:0] PRE_HALF = PW'(TIMER_SCALE / 2);
`endif

    // Expiry happens on the tick where the seconds count equals T-1.
    localparam logic [7:0] LAST_MIN_GREEN = 8'(T_MIN_GREEN - 1);
    localparam logic [7:0] LAST_YELLOW    = 8'(T_YELLOW - 1);
    localparam logic [7:0] LAST_ALL_RED   = 8'(T_ALL_RED - 1);
    localparam logic [7:0] LAST_WALK      = 8'(T_WALK - 1);
    localparam logic [7:0] LAST_CLEAR     = 8'(T_CLEAR - 1);

    typedef enum logic [2:0] {
        STARTUP,
        ROADGREEN,
        ROADYELLOW,
        ALLRED1,
        PEDWALK,
        PEDCLEAR,
        ALLRED2
    } phase_t;

    phase_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    sec_q, sec_d;
    logic          minDone_q, minDone_d;
    logic          req_q, req_d;
    logic          syncMeta_q, syncOut_q, syncPrev_q;
    logic          green_q, green_d;
    logic          yellow_q, yellow_d;
    logic          red_q, red_d;
    logic          pedGreen_q, pedGreen_d;
    logic          pedRed_q, pedRed_d;

    logic          tick;
    logic          expire;
    logic          btnRise;
    logic [7:0]    lastSec;

    // Next-state, timer, request and lamp computation. The lamps are decoded
    // from the next state so that they change on the same edge as the state.
    always_comb begin
        tick    = (pre_q == PRE_LAST);
        btnRise = syncOut_q & ~syncPrev_q;

        case (state_q)
            ROADGREEN:  lastSec = LAST_MIN_GREEN;
            ROADYELLOW: lastSec = LAST_YELLOW;
            PEDWALK:    lastSec = LAST_WALK;
            PEDCLEAR:   lastSec = LAST_CLEAR;
            default:    lastSec = LAST_ALL_RED;
        endcase
        expire = tick && (sec_q == lastSec);

        state_d = state_q;
        case (state_q)
            STARTUP:    if (expire) state_d = ROADGREEN;
            ROADGREEN:  if ((minDone_q || expire) && req_q) state_d = ROADYELLOW;
            ROADYELLOW: if (expire) state_d = ALLRED1;
            ALLRED1:    if (expire) state_d = PEDWALK;
            PEDWALK:    if (expire) state_d = PEDCLEAR;
            PEDCLEAR:   if (expire) state_d = ALLRED2;
            ALLRED2:    if (expire) state_d = ROADGREEN;
            default:    state_d = STARTUP;
        endcase

        // Every phase starts with a fresh prescaler, seconds count and
        // minimum-green flag.
        if (state_d != state_q) begin
            pre_d     = '0;
            sec_d     = 8'd0;
            minDone_d = 1'b0;
        end else begin
            pre_d     = tick ? '0 : pre_q + PW'(1);
            sec_d     = (tick && (sec_q != 8'hFF)) ? sec_q + 8'd1 : sec_q;
            minDone_d = minDone_q | ((state_q == ROADGREEN) && expire);
        end

        // Entering the walk phase serves the request and wins over a
        // coincident button edge; edges during the walk itself are dropped.
        if ((state_d == PEDWALK) && (state_q != PEDWALK)) begin
            req_d = 1'b0;
        end else if (state_q == PEDWALK) begin
            req_d = req_q;
        end else begin
            req_d = req_q | btnRise;
        end

        green_d    = 1'b0;
        yellow_d   = 1'b0;
        red_d      = 1'b1;
        pedGreen_d = 1'b0;
        pedRed_d   = 1'b1;
        case (state_d)
            ROADGREEN: begin
                green_d = 1'b1;
                red_d   = 1'b0;
            end
            ROADYELLOW: begin
                yellow_d = 1'b1;
                red_d    = 1'b0;
            end
            PEDWALK: begin
                pedGreen_d = 1'b1;
                pedRed_d   = 1'b0;
            end
            PEDCLEAR: begin
`ifdef PED_FLASH_EN
                // Lit for the first half of every second, starting on entry.
                pedGreen_d = (pre_d < PRE_HALF);
                pedRed_d   = 1'b0;
`else
                pedRed_d   = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // All state, timers, synchroniser and lamps.
    always_ff @(posedge pin3_clk_16mhz or negedge pin9_rst_n) begin
        if (!pin9_rst_n) begin
            state_q    <= STARTUP;
            pre_q      <= '0;
            sec_q      <= 8'd0;
            minDone_q  <= 1'b0;
            req_q      <= 1'b0;
            syncMeta_q <= 1'b0;
            syncOut_q  <= 1'b0;
            syncPrev_q <= 1'b0;
            green_q    <= 1'b0;
            yellow_q   <= 1'b0;
            red_q      <= 1'b1;
            pedGreen_q <= 1'b0;
            pedRed_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            sec_q      <= sec_d;
            minDone_q  <= minDone_d;
            req_q      <= req_d;
            syncMeta_q <= pin10_ped_button;
            syncOut_q  <= syncMeta_q;
            syncPrev_q <= syncOut_q;
            green_q    <= green_d;
            yellow_q   <= yellow_d;
            red_q      <= red_d;
            pedGreen_q <= pedGreen_d;
            pedRed_q   <= pedRed_d;
        end
    end

    assign pin4_green     = green_q;
    assign pin5_yellow    = yellow_q;
    assign pin6_red       = red_q;
    assign pin7_ped_green = pedGreen_q;
    assign pin8_ped_red   = pedRed_q;
    assign pin11_wait     = req_q;

endmodule

// File: doc/ped_crossing.md
PED_CROSSING -- requirements
Module: ped_crossing

Interface
REQ-001 Parameter TIMER_SCALE, default 16000000, clock cycles per second; range 2..2^30.
REQ-002 Parameter T_MIN_GREEN, default 10, minimum road-green seconds; range 1..255.
REQ-003 Parameter T_YELLOW, default 3, road-yellow seconds; range 1..255.
REQ-004 Parameter T_ALL_RED, default 2, all-red clearance seconds, used both before and after the walk phase; range 1..255.
REQ-005 Parameter T_WALK, default 8, pedestrian-walk seconds; range 1..255.
REQ-006 Parameter T_CLEAR, default 4, pedestrian-clearance seconds; range 1..255.
REQ-007 pin3_clk_16mhz  input  1  sole clock; all state changes on its rising edge.
REQ-008 pin9_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-009 pin10_ped_button  input  1  pedestrian push button, asynchronous, active-high.
REQ-010 pin4_green / pin5_yellow / pin6_red  output  1 each  road lamps.
REQ-011 pin7_ped_green / pin8_ped_red  output  1 each  pedestrian lamps.
REQ-012 pin11_wait  output  1  "request registered" indicator, equal to the internal request flag.

Function
REQ-013 States SHALL be: STARTUP, ROADGREEN, ROADYELLOW, ALLRED1, PEDWALK, PEDCLEAR, ALLRED2.
REQ-014 Sequence SHALL be STARTUP -> ROADGREEN -> ROADYELLOW -> ALLRED1 -> PEDWALK -> PEDCLEAR -> ALLRED2 -> ROADGREEN.
REQ-015 Phase timing SHALL be as follows.
- On every state entry, the prescaler and the seconds counter are cleared to 0.
- A tick occurs when prescaler == TIMER_SCALE-1; the prescaler then wraps to 0 and the seconds counter increments.
REQ-016 A timed phase of T seconds SHALL expire on the tick where seconds == T-1, so the phase lasts exactly T*TIMER_SCALE cycles.
- STARTUP uses T_ALL_RED.
- Every other timed phase uses its own parameter.
REQ-017 Prescaler width SHALL be $clog2(TIMER_SCALE). The seconds counter SHALL be 8 bits and saturate at 255.
REQ-018 ROADGREEN SHALL NOT expire on time alone.
- A sticky min_done flag sets on the T_MIN_GREEN expiry tick.
- The state exits on the first cycle in which (min_done or the expiry tick) AND the request flag is set.
- With no request, ROADGREEN holds indefinitely.
REQ-019 pin10_ped_button SHALL pass through a 2-flop synchroniser. A rising edge at the synchroniser output sets the request flag on the following edge.
REQ-020 The request flag SHALL clear on entry to PEDWALK.
- Rising edges seen while in PEDWALK are ignored.
- Rising edges in any other state, including PEDCLEAR and ALLRED2, are latched for the next cycle.
REQ-021 Clear-on-entry SHALL take priority over a simultaneous rising edge.
REQ-022 Lamp decode SHALL be:
- ROADGREEN: green + ped_red.
- ROADYELLOW: yellow + ped_red.
- STARTUP, ALLRED1 and ALLRED2: red + ped_red.
- PEDWALK: red + ped_green.
- PEDCLEAR: red, with pedestrian lamps per REQ-026.
REQ-023 Lamps SHALL be registered from next-state values, so lamps change on the same edge as the state. At most one road lamp and one pedestrian lamp are lit in any cycle.
REQ-024 Road green or yellow and ped_green SHALL never be lit in the same cycle.

Reset
REQ-025 While pin9_rst_n is low, the block SHALL hold:
- state STARTUP;
- prescaler, seconds, min_done, request flag and synchroniser all 0;
- red=1, ped_red=1, all other lamps 0, wait=0.
After release, STARTUP runs T_ALL_RED seconds. Reset asserted mid-phase SHALL abort the phase immediately, asynchronously.

Configuration
REQ-026 Macro PED_FLASH_EN selects the PEDCLEAR pedestrian display.
- When defined: ped_red=0 and ped_green is lit while prescaler < TIMER_SCALE/2, dark otherwise, i.e. it flashes at 1 Hz starting lit on entry.
- When undefined: ped_red=1 and ped_green=0 for all of PEDCLEAR.

Verification (TIMER_SCALE=4, T_MIN_GREEN=3, T_YELLOW=2, T_ALL_RED=1, T_WALK=2, T_CLEAR=2)
REQ-027 Reset release, no button -> red for 4 cycles, then green held for 200+ cycles with wait=0.
REQ-028 Button pulse at cycle 2 of green -> wait=1 after 3 edges.
- Green persists until 12 cycles after entry.
- Then yellow 8 cycles, all-red 4, walk 8 (wait drops at walk entry), clear 8, all-red 4, green.
REQ-029 Button pressed at cycle 40 of green (min_done already set) -> green leaves 1 cycle after wait rises.
REQ-030 Button pulsed during PEDWALK -> wait stays 0 and the next green holds indefinitely. Button pulsed during PEDCLEAR -> wait=1, and the next green exits at exactly 12 cycles.
REQ-031 PED_FLASH_EN defined -> during PEDCLEAR, ped_green pattern 1,1,0,0,1,1,0,0 and ped_red=0. Undefined -> ped_red=1 throughout.
REQ-032 pin9_rst_n pulsed low mid-PEDWALK -> outputs red=1, ped_red=1, wait=0 in the same cycle, without waiting for a clock edge; STARTUP then restarts.
